byte_word_packer: RTL and testbench

- Stage directly upstream of consumers that read 32-bit words; it consumes the byte stream carried on the data_if payload (byte_t, 8 bits).
- Packs consecutive bytes little-endian into BYTES-wide words, with a per-byte keep mask and a frame-last flag.
- Module header carries a package import of IfcPkg::* so that byte_t is used for the input byte.
- Valid/ready handshake on both sides; one output holding register.

---
 rtl/byte_word_packer.sv | 81 ++++++++
 tb/tb_byte_word_packer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/byte_word_packer.sv
// Byte-to-word packer: gathers a byte stream little-endian into BYTES-wide
// words with a keep mask and frame-last flag behind one output register.
package IfcPkg;
    typedef logic [7:0] byte_t;
endpackage

module byte_word_packer
    import IfcPkg::*;
#(
    parameter int BYTES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  byte_t              in_data,
    input  logic               in_last,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BYTES*8-1:0] out_data,
    output logic [BYTES-1:0]   out_keep,
    output logic               out_last
);

    localparam int CW = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [CW-1:0] LAST_SLOT = CW'(BYTES - 1);

    logic [CW-1:0]      count;
    logic [BYTES*8-1:0] acc;
    logic [BYTES*8-1:0] merged;
    logic [BYTES-1:0]   fill_keep;
    logic               accept;
    logic               xfer;
    logic               complete;
    int                 fill;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign xfer     = out_valid && out_ready;

    always_comb begin
        merged    = acc;
        fill_keep = '0;
        fill      = accept ? int'(count) + 1 : int'(count);
        for (int k = 0; k < BYTES; k++) begin
            if (accept && k == int'(count))
                merged[8*k +: 8] = in_data;
            fill_keep[k] = (k < fill);
        end
        // A flush only closes a word when there is something to emit.
        complete = (accept && (count == LAST_SLOT || in_last))
                || (flush && in_ready && (accept || count != '0));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
            out_last  <= 1'b0;
            count     <= '0;
            acc       <= '0;
        end else if (complete) begin
            out_valid <= 1'b1;
            out_data  <= merged;
            out_keep  <= fill_keep;
            out_last  <= accept && in_last;
            count     <= '0;
            acc       <= '0;
        end else begin
            if (xfer)
                out_valid <= 1'b0;
            if (accept) begin
                acc   <= merged;
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_byte_word_packer.sv
// Directed and random checks of byte_word_packer against a byte-queue model.
module tb_byte_word_packer;
    localparam int BYTES = 4;

    logic              clk = 0;
    logic              rst;
    logic              in_valid, in_ready, in_last, flush;
    logic [7:0]        in_data;
    logic              out_valid, out_ready, out_last;
    logic [BYTES*8-1:0] out_data;
    logic [BYTES-1:0]  out_keep;

    byte_word_packer #(.BYTES(BYTES)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_keep(out_keep), .out_last(out_last)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int dut_xfers = 0;

    // Model: bytes accepted but not yet emitted, and the word on the output.
    logic [7:0]         pend[$];
    logic               m_valid;
    logic [BYTES*8-1:0] m_data;
    logic [BYTES-1:0]   m_keep;
    logic               m_last;
    logic               m_acc;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        m_valid = 0;
        m_data  = '0;
        m_keep  = '0;
        m_last  = 0;
    endtask

    task automatic step(bit v, bit [7:0] d, bit l, bit f, bit r);
        bit exp_rdy;
        @(negedge clk);
        in_valid = v; in_data = d; in_last = l; flush = f; out_ready = r;
        #1;
        exp_rdy = !m_valid || r;
        chk("in_ready", in_ready, exp_rdy);
        m_acc = v && exp_rdy;
        if (out_valid && r) dut_xfers++;
        if (m_valid && r) begin
            chk("xfer_data", out_data, m_data);
            chk("xfer_keep", out_keep, m_keep);
            chk("xfer_last", out_last, m_last);
            m_valid = 0;
        end
        if (m_acc) pend.push_back(d);
        if ((m_acc && (pend.size() == BYTES || l))
            || (exp_rdy && f && pend.size() > 0)) begin
            m_data = '0;
            foreach (pend[i]) m_data |= (BYTES*8)'(pend[i]) << (8*i);
            m_keep = BYTES'((1 << pend.size()) - 1);
            m_last = m_acc && l;
            m_valid = 1;
            pend.delete();
        end
        @(posedge clk);
        #1;
        chk("out_valid", out_valid, m_valid);
        if (m_valid) begin
            chk("out_data", out_data, m_data);
            chk("out_keep", out_keep, m_keep);
            chk("out_last", out_last, m_last);
        end
    endtask

    task automatic send(bit [7:0] d, bit l, bit r);
        int tries = 0;
        do begin
            step(1, d, l, 0, r);
            tries++;
        end while (!m_acc && tries < 20);
        if (!m_acc) chk("send_timeout", 0, 1);
    endtask

    task automatic idle(int n);
        repeat (n) step(0, 8'h00, 0, 0, 1);
    endtask

    task automatic check_reset_outputs(string tag);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_data"}, out_data, 0);
        chk({tag, "_keep"}, out_keep, 0);
        chk({tag, "_last"}, out_last, 0);
        chk({tag, "_ready"}, in_ready, 1);
    endtask

    initial begin
        int base;
        in_valid = 0; in_data = 0; in_last = 0; flush = 0; out_ready = 1;
        rst = 1;
        model_reset();
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 0;

        // Single full frame
        send(8'h11, 0, 1); send(8'h22, 0, 1);
        send(8'h33, 0, 1); send(8'h44, 1, 1);
        chk("t1_data", out_data, 32'h44332211);
        chk("t1_keep", out_keep, 4'b1111);
        idle(1);

        // Short frame
        send(8'hA1, 0, 1); send(8'hA2, 1, 1);
        chk("t2_data", out_data, 32'h0000A2A1);
        chk("t2_keep", out_keep, 4'b0011);
        idle(1);

        // Flush of a partial word
        send(8'h01, 0, 1); send(8'h02, 0, 1); send(8'h03, 0, 1);
        step(0, 8'h00, 0, 1, 1);
        chk("t3_data", out_data, 32'h00030201);
        chk("t3_keep", out_keep, 4'b0111);
        chk("t3_last", out_last, 0);
        send(8'h04, 1, 1);
        chk("t3_slot0", out_data, 32'h00000004);
        idle(1);

        // Backpressure holds the first word
        for (int i = 0; i < 4; i++) send(8'(i), 0, 1);
        repeat (3) step(1, 8'h04, 0, 0, 0);
        chk("t4_hold", out_data, 32'h03020100);
        for (int i = 4; i < 8; i++) send(8'(i), 0, 1);
        chk("t4_second", out_data, 32'h07060504);
        idle(1);

        // Back-to-back words at full rate
        base = dut_xfers;
        for (int i = 0; i < 16; i++) step(1, 8'(8'h80 + i), 0, 0, 1);
        idle(1);
        chk("t5_words", dut_xfers - base, 4);

        // Reset mid-frame
        send(8'hE1, 0, 1); send(8'hE2, 0, 1);
        @(negedge clk);
        rst = 1;
        in_valid = 0;
        #1;
        check_reset_outputs("midrst");
        model_reset();
        @(negedge clk);
        rst = 0;
        idle(2);
        send(8'hFF, 1, 1);
        chk("t6_data", out_data, 32'h000000FF);
        chk("t6_keep", out_keep, 4'b0001);
        idle(1);

        // Random traffic
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, 8'($urandom),
                 $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 9) < 7);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
